// File: rtl/ntt_sdf_reorder_pkg.sv
// ---------------------------------------------------------------------------
// ntt_sdf_reorder_pkg
//   Shared defaults and sizing helpers for the SDF NTT output reorder buffer.
//   Imported by ntt_sdf_reorder and ntt_reorder_ram.
// ---------------------------------------------------------------------------
package ntt_sdf_reorder_pkg;

   localparam int LOGQ_DEFAULT       = 64;  // coefficient width
   localparam int LOGN_DEFAULT       = 10;  // log2 of frame length
   localparam int DELAY_BRAM_DEFAULT = 1;   // buffer RAM read latency
   localparam int BITREV_DEFAULT     = 1;   // bit-reversed write addressing

   // Two ping-pong banks: one filling while the other drains.
   localparam int NUM_BANKS = 2;

   // Output FIFO must absorb every read that is still in the RAM pipeline
   // when downstream stalls, plus one registered head and one spare slot so
   // a steady 1/cycle stream never has to pause for the occupancy check.
   function automatic int fifo_depth(input int delay_bram);
      return delay_bram + 2;
   endfunction

endpackage

// File: rtl/ntt_reorder_ram.sv
// ---------------------------------------------------------------------------
// ntt_reorder_ram
//   Simple dual-port coefficient buffer, 2^ADDR_W words of LOGQ bits.
//   One synchronous write port, one read port with a registered read path of
//   DELAY_BRAM cycles. No reset: contents and read pipeline are pure data.
// Ports
//   clk    in  clock
//   we     in  write enable
//   waddr  in  write address  [ADDR_W]
//   wdata  in  write data     [LOGQ]
//   re     in  read issue (loads the first read register)
//   raddr  in  read address   [ADDR_W]
//   rdata  out read data, valid DELAY_BRAM cycles after re
// ---------------------------------------------------------------------------
module ntt_reorder_ram
   import ntt_sdf_reorder_pkg::*;
#(
   parameter int LOGQ       = LOGQ_DEFAULT,
   parameter int ADDR_W     = LOGN_DEFAULT + 1,
   parameter int DELAY_BRAM = DELAY_BRAM_DEFAULT
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [LOGQ-1:0]   wdata,
   input  logic              re,
   input  logic [ADDR_W-1:0] raddr,
   output logic [LOGQ-1:0]   rdata
);

   localparam int WORDS = 1 << ADDR_W;

   logic [LOGQ-1:0] mem  [WORDS];
   logic [LOGQ-1:0] rd_p [DELAY_BRAM];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   // ---- read stage p0 -> p1..pD: registered array read, then extra delay ----
   always_ff @(posedge clk) begin
      if (re) begin
         rd_p[0] <= mem[raddr];
      end
      for (int i = 1; i < DELAY_BRAM; i++) begin
         rd_p[i] <= rd_p[i-1];
      end
   end

   assign rdata = rd_p[DELAY_BRAM-1];

endmodule

// File: rtl/ntt_sdf_reorder.sv
// ---------------------------------------------------------------------------
// ntt_sdf_reorder
//   Output-side bit-reversal reorder buffer for the SDF NTT pipeline.
//   Accepts the scrambled serial coefficient stream from the last SDF stage
//   and emits each N-coefficient frame in natural order over a valid/ready
//   handshake. Two ping-pong banks let a new frame stream in while the
//   previous one drains; a small register FIFO hides the RAM read latency so
//   out_ready backpressure never loses data.
// Ports
//   clk        in  clock
//   rst        in  synchronous active-high reset
//   start      in  input sample valid
//   stage_in   in  input coefficient [LOGQ]
//   out_ready  in  downstream accepts stage_out this cycle
//   finish     out stage_out valid
//   stage_out  out output coefficient, natural order [LOGQ]
//   frame_last out qualifies finish: coefficient N-1 of a frame
//   overflow   out sticky: a sample arrived while the write bank was full
// ---------------------------------------------------------------------------
module ntt_sdf_reorder
   import ntt_sdf_reorder_pkg::*;
#(
   parameter int LOGQ       = LOGQ_DEFAULT,
   parameter int LOGN       = LOGN_DEFAULT,
   parameter int DELAY_BRAM = DELAY_BRAM_DEFAULT,
   parameter int BITREV     = BITREV_DEFAULT
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [LOGQ-1:0] stage_in,
   input  logic            out_ready,
   output logic            finish,
   output logic [LOGQ-1:0] stage_out,
   output logic            frame_last,
   output logic            overflow
);

   localparam int DEPTH = fifo_depth(DELAY_BRAM);
   localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW    = $clog2(DEPTH + 1);

   // Write side
   logic [LOGN-1:0]      wr_cnt;
   logic [LOGN-1:0]      wr_rev;
   logic [LOGN-1:0]      wr_addr_lo;
   logic                 wr_bank;
   logic                 wr_en;
   logic [NUM_BANKS-1:0] full;

   // Read side
   logic [LOGN-1:0]      rd_cnt;
   logic                 rd_bank;
   logic                 rd_issue_p0;
   logic                 last_p0;
   logic [LOGQ-1:0]      ram_rdata;
   logic [DELAY_BRAM-1:0] vld_p;
   logic [DELAY_BRAM-1:0] last_p;
   logic                 push;

   // Output FIFO
   logic [LOGQ:0]        fifo_mem [DEPTH];
   logic [PW-1:0]        wptr;
   logic [PW-1:0]        rptr;
   logic [CW-1:0]        fifo_count;
   logic [CW-1:0]        in_flight;
   logic [LOGQ:0]        head;
   logic                 pop;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   // ---- write stage: address generation and bank fill ----
   always_comb begin
      wr_rev = '0;
      for (int i = 0; i < LOGN; i++) begin
         wr_rev[i] = wr_cnt[LOGN-1-i];
      end
   end

   assign wr_addr_lo = (BITREV != 0) ? wr_rev : wr_cnt;
   assign wr_en      = start & ~full[wr_bank];

   // A read is only issued if its data is guaranteed a FIFO slot on arrival,
   // counting reads still travelling through the RAM pipeline.
   assign rd_issue_p0 = full[rd_bank] &&
                        (({1'b0, fifo_count} + {1'b0, in_flight}) < (CW+1)'(DEPTH));
   assign last_p0     = (rd_cnt == '1);

   // Write wrap sets full[wr_bank] and read wrap clears full[rd_bank]; the two
   // banks always differ because writes need full=0 and reads need full=1.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_cnt   <= '0;
         wr_bank  <= 1'b0;
         rd_cnt   <= '0;
         rd_bank  <= 1'b0;
         full     <= '0;
         overflow <= 1'b0;
      end else begin
         if (start && full[wr_bank]) begin
            overflow <= 1'b1;
         end
         if (wr_en) begin
            wr_cnt <= wr_cnt + 1'b1;
            if (wr_cnt == '1) begin
               full[wr_bank] <= 1'b1;
               wr_bank       <= ~wr_bank;
            end
         end
         if (rd_issue_p0) begin
            rd_cnt <= rd_cnt + 1'b1;
            if (last_p0) begin
               full[rd_bank] <= 1'b0;
               rd_bank       <= ~rd_bank;
            end
         end
      end
   end

   ntt_reorder_ram #(
      .LOGQ       (LOGQ),
      .ADDR_W     (LOGN + 1),
      .DELAY_BRAM (DELAY_BRAM)
   ) u_ram (
      .clk   (clk),
      .we    (wr_en),
      .waddr ({wr_bank, wr_addr_lo}),
      .wdata (stage_in),
      .re    (rd_issue_p0),
      .raddr ({rd_bank, rd_cnt}),
      .rdata (ram_rdata)
   );

   // ---- read stage p0 -> pD: valid/last travel alongside RAM latency ----
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_p <= '0;
      end else begin
         vld_p[0] <= rd_issue_p0;
         for (int i = 1; i < DELAY_BRAM; i++) begin
            vld_p[i] <= vld_p[i-1];
         end
      end
   end

   always_ff @(posedge clk) begin
      last_p[0] <= last_p0;
      for (int i = 1; i < DELAY_BRAM; i++) begin
         last_p[i] <= last_p[i-1];
      end
   end

   assign push = vld_p[DELAY_BRAM-1];

   // ---- FIFO stage: first-word-fall-through output buffer ----
   assign finish = (fifo_count != '0);
   assign pop    = finish & out_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr       <= '0;
         rptr       <= '0;
         fifo_count <= '0;
         in_flight  <= '0;
      end else begin
         if (push) begin
            wptr <= ptr_inc(wptr);
         end
         if (pop) begin
            rptr <= ptr_inc(rptr);
         end
         fifo_count <= fifo_count + CW'(push) - CW'(pop);
         in_flight  <= in_flight + CW'(rd_issue_p0) - CW'(push);
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem[wptr] <= {last_p[DELAY_BRAM-1], ram_rdata};
      end
   end

   // Head is gated by finish so outputs read as zero whenever nothing is valid,
   // without needing to reset the storage registers.
   assign head       = fifo_mem[rptr];
   assign stage_out  = finish ? head[LOGQ-1:0] : '0;
   assign frame_last = finish & head[LOGQ];

endmodule

// File: tb/tb_ntt_sdf_reorder.sv
// ---------------------------------------------------------------------------
// tb_ntt_sdf_reorder
//   Directed bench for the SDF NTT output reorder buffer (N=16, LOGQ=64).
//   dut1: BITREV=1, DELAY_BRAM=1.  dut2: BITREV=0, DELAY_BRAM=2 (same inputs).
// ---------------------------------------------------------------------------
module tb_ntt_sdf_reorder;

   localparam int LOGQ = 64;
   localparam int LOGN = 4;
   localparam int N    = 16;

   logic            clk = 1'b0;
   logic            rst;
   logic            start;
   logic [LOGQ-1:0] stage_in;
   logic            out_ready;

   logic            finish, frame_last, overflow;
   logic [LOGQ-1:0] stage_out;
   logic            finish2, last2, ovf2;
   logic [LOGQ-1:0] out2;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int t0       = 0;

   typedef struct {
      logic [LOGQ-1:0] din;
      logic [LOGQ-1:0] dout;
      logic            last;
   } vec_t;

   typedef struct {
      logic [LOGQ-1:0] d;
      logic            l;
      int              c;
   } obs_t;

   vec_t tbl [N];
   obs_t q1 [$];
   obs_t q2 [$];

   ntt_sdf_reorder #(
      .LOGQ(LOGQ), .LOGN(LOGN), .DELAY_BRAM(1), .BITREV(1)
   ) dut1 (
      .clk(clk), .rst(rst), .start(start), .stage_in(stage_in),
      .out_ready(out_ready), .finish(finish), .stage_out(stage_out),
      .frame_last(frame_last), .overflow(overflow)
   );

   ntt_sdf_reorder #(
      .LOGQ(LOGQ), .LOGN(LOGN), .DELAY_BRAM(2), .BITREV(0)
   ) dut2 (
      .clk(clk), .rst(rst), .start(start), .stage_in(stage_in),
      .out_ready(out_ready), .finish(finish2), .stage_out(out2),
      .frame_last(last2), .overflow(ovf2)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [LOGQ-1:0] act, input logic [LOGQ-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   // Output monitor plus stall-stability check on dut1.
   logic            prev_stall = 1'b0;
   logic [LOGQ-1:0] prev_d;
   logic            prev_l;

   always @(negedge clk) begin
      if (finish && out_ready) q1.push_back('{stage_out, frame_last, cyc});
      if (finish2 && out_ready) q2.push_back('{out2, last2, cyc});
      if (prev_stall) begin
         checks++;
         if (!finish || stage_out !== prev_d || frame_last !== prev_l) begin
            failures++;
            $display("FAIL stall_hold actual=%0d/%0d/%0d required=1/%0d/%0d",
                     finish, stage_out, frame_last, prev_d, prev_l);
         end
      end
      prev_stall = finish && !out_ready && !rst;
      prev_d     = stage_out;
      prev_l     = frame_last;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst   = 1'b1;
      start = 1'b0;
      repeat (2) tick();
      rst   = 1'b0;
   endtask

   task automatic send(input logic [LOGQ-1:0] base, input int n);
      for (int i = 0; i < n; i++) begin
         start    = 1'b1;
         stage_in = base + tbl[i % N].din;
         tick();
      end
      start = 1'b0;
   endtask

   task automatic wait_q(input int which, input int n, input int budget);
      int k = 0;
      while (((which == 1) ? q1.size() : q2.size()) < n && k < budget) begin
         tick();
         k++;
      end
   endtask

   initial begin
      int exp_br [N] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};
      for (int i = 0; i < N; i++) begin
         tbl[i].din  = LOGQ'(i);
         tbl[i].dout = LOGQ'(exp_br[i]);
         tbl[i].last = (i == N - 1);
      end

      rst = 1'b1; start = 1'b0; stage_in = '0; out_ready = 1'b1;
      repeat (3) tick();
      rst = 1'b0;

      // Reset state
      chk("rst_finish", finish, 0);
      chk("rst_stage_out", stage_out, 0);
      chk("rst_frame_last", frame_last, 0);
      chk("rst_overflow", overflow, 0);

      // Test 1: single frame
      q1.delete(); t0 = cyc;
      send(0, N);
      wait_q(1, N, 60);
      chk("t1_count", q1.size(), N);
      for (int i = 0; i < N && i < q1.size(); i++) begin
         chk($sformatf("t1_data[%0d]", i), q1[i].d, tbl[i].dout);
         chk($sformatf("t1_last[%0d]", i), q1[i].l, tbl[i].last);
         chk($sformatf("t1_cycle[%0d]", i), q1[i].c - t0, 18 + i);
      end

      // Test 2: four back-to-back frames
      do_reset(); q1.delete(); t0 = cyc;
      for (int k = 0; k < 4 * N; k++) begin
         start = 1'b1; stage_in = LOGQ'(k); tick();
      end
      start = 1'b0;
      wait_q(1, 4 * N, 80);
      chk("t2_count", q1.size(), 4 * N);
      for (int k = 0; k < 4 * N && k < q1.size(); k++) begin
         chk($sformatf("t2_data[%0d]", k), q1[k].d, LOGQ'((k / N) * N) + tbl[k % N].dout);
         chk($sformatf("t2_last[%0d]", k), q1[k].l, tbl[k % N].last);
         chk($sformatf("t2_cycle[%0d]", k), q1[k].c - t0, 18 + k);
      end
      chk("t2_overflow", overflow, 0);

      // Test 3: backpressure pattern 1,0,0,1
      do_reset(); q1.delete(); t0 = cyc;
      for (int k = 0; k < 100; k++) begin
         start     = (k < N);
         stage_in  = LOGQ'(k);
         out_ready = (k % 4 == 0) || (k % 4 == 3);
         tick();
      end
      start = 1'b0; out_ready = 1'b1;
      repeat (10) tick();
      chk("t3_count", q1.size(), N);
      for (int i = 0; i < N && i < q1.size(); i++) begin
         chk($sformatf("t3_data[%0d]", i), q1[i].d, tbl[i].dout);
         chk($sformatf("t3_last[%0d]", i), q1[i].l, tbl[i].last);
      end

      // Test 4: overflow with output stalled
      do_reset(); q1.delete(); out_ready = 1'b0; t0 = cyc;
      for (int k = 0; k < 3 * N; k++) begin
         if (k == 2 * N) chk("t4_ovf_before", overflow, 0);
         start = 1'b1; stage_in = LOGQ'(k); tick();
         if (k == 2 * N) chk("t4_ovf_after", overflow, 1);
      end
      start = 1'b0;
      repeat (5) tick();
      chk("t4_stalled_count", q1.size(), 0);
      chk("t4_stalled_finish", finish, 1);
      out_ready = 1'b1;
      repeat (60) tick();
      chk("t4_count", q1.size(), 2 * N);
      for (int k = 0; k < 2 * N && k < q1.size(); k++) begin
         chk($sformatf("t4_data[%0d]", k), q1[k].d, LOGQ'((k / N) * N) + tbl[k % N].dout);
         chk($sformatf("t4_last[%0d]", k), q1[k].l, tbl[k % N].last);
      end
      chk("t4_ovf_sticky", overflow, 1);

      // Test 5: reset at sample 8 of frame 2 while frame 1 drains
      chk("t5_ovf_before", overflow, 1);
      q1.delete();
      send(100, N);
      send(200, 8);
      rst = 1'b1; start = 1'b0;
      tick();
      rst = 1'b0;
      chk("t5_finish_after_rst", finish, 0);
      chk("t5_ovf_after_rst", overflow, 0);
      chk("t5_last_after_rst", frame_last, 0);
      chk("t5_out_after_rst", stage_out, 0);
      q1.delete(); t0 = cyc;
      send(300, N);
      wait_q(1, N, 60);
      chk("t5_count", q1.size(), N);
      for (int i = 0; i < N && i < q1.size(); i++) begin
         chk($sformatf("t5_data[%0d]", i), q1[i].d, 300 + tbl[i].dout);
         chk($sformatf("t5_cycle[%0d]", i), q1[i].c - t0, 18 + i);
      end

      // Test 6: BITREV=0, DELAY_BRAM=2 instance
      do_reset(); q2.delete(); t0 = cyc;
      send(0, N);
      wait_q(2, N, 60);
      chk("t6_count", q2.size(), N);
      for (int i = 0; i < N && i < q2.size(); i++) begin
         chk($sformatf("t6_data[%0d]", i), q2[i].d, tbl[i].din);
         chk($sformatf("t6_last[%0d]", i), q2[i].l, tbl[i].last);
         chk($sformatf("t6_cycle[%0d]", i), q2[i].c - t0, 19 + i);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
